cpu_mem_ctrl: RTL and testbench

//  Memory-side bridge downstream of the Cpu core: accepts the Cpu's registered read/write request,

---
 rtl/cpu_mem_ctrl_pkg.sv | 35 +++
 rtl/cpu_mem_lane_steer.sv | 54 +++++
 rtl/cpu_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_cpu_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_ctrl_pkg.sv
// Shared types and constants for the Cpu memory-side bridge.
//   ReqDataSz            - Cpu transfer size encoding (8/16/32/48 bits)
//   MemCtrlState         - bridge FSM states
//   mem_ctrl_num_beats() - number of 16-bit memory beats for a transfer size
package cpu_mem_ctrl_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_MAX_W = 48;
    localparam int MEM_W      = 16;

    localparam int mem_ctrl_timeout_cyc = 255;

    typedef enum logic [1:0] {
        ReqDataSz8  = 2'd0,
        ReqDataSz16 = 2'd1,
        ReqDataSz32 = 2'd2,
        ReqDataSz48 = 2'd3
    } ReqDataSz;

    typedef enum logic {
        MemIdle = 1'b0,
        MemBeat = 1'b1
    } MemCtrlState;

    function automatic logic [1:0] mem_ctrl_num_beats(input ReqDataSz size);
        logic [1:0] n;
        case (size)
            ReqDataSz32: n = 2'd2;
            ReqDataSz48: n = 2'd3;
            default:     n = 2'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cpu_mem_lane_steer.sv
// Combinational byte-lane steering between the Cpu data bus and the 16-bit memory beat.
//   size, addr_lsb, beat_idx - latched transfer description and current beat
//   wr_data                  - latched Cpu write data
//   rd_data, rd_asm          - memory beat read data and read assembly register
//   be, wr_beat              - byte enables and write data for the current beat
//   rd_merged                - assembly register with the current beat merged in
//   rd_result                - final Cpu read value (8b reads pick one lane, zero-extended)
module cpu_mem_lane_steer
    import cpu_mem_ctrl_pkg::*;
(
    input  ReqDataSz              size,
    input  logic                  addr_lsb,
    input  logic [1:0]            beat_idx,
    input  logic [DATA_MAX_W-1:0] wr_data,
    input  logic [MEM_W-1:0]      rd_data,
    input  logic [DATA_MAX_W-1:0] rd_asm,
    output logic [1:0]            be,
    output logic [MEM_W-1:0]      wr_beat,
    output logic [DATA_MAX_W-1:0] rd_merged,
    output logic [DATA_MAX_W-1:0] rd_result
);

    always_comb begin
        be        = 2'b11;
        wr_beat   = '0;
        rd_merged = rd_asm;
        rd_result = '0;

        if (size == ReqDataSz8) begin
            be      = addr_lsb ? 2'b10 : 2'b01;
            // Byte replicated on both lanes so memory sees it whichever lane is enabled.
            wr_beat = {wr_data[7:0], wr_data[7:0]};
        end else begin
            case (beat_idx)
                2'd1:    wr_beat = wr_data[31:16];
                2'd2:    wr_beat = wr_data[47:32];
                default: wr_beat = wr_data[15:0];
            endcase
        end

        case (beat_idx)
            2'd0:    rd_merged = {rd_asm[47:16], rd_data};
            2'd1:    rd_merged = {rd_asm[47:32], rd_data, rd_asm[15:0]};
            2'd2:    rd_merged = {rd_data, rd_asm[31:0]};
            default: rd_merged = rd_asm;
        endcase

        if (size == ReqDataSz8)
            rd_result = DATA_MAX_W'(addr_lsb ? rd_merged[15:8] : rd_merged[7:0]);
        else
            rd_result = rd_merged;
    end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// Memory-side bridge for the Cpu core: splits a registered Cpu request into
// 16-bit memory beats and returns assembled read data, stalling the Cpu meanwhile.
//   clk, rst                         - clock, synchronous active-high reset
//   cpu_req_rd/wr/size, cpu_addr,
//   cpu_wr_data                      - Cpu request
//   cpu_enable, cpu_data_in          - Cpu stall control and read data
//   mem_req/we/be/addr/wr_data,
//   mem_rd_data, mem_ack             - 16-bit memory beat interface
//   err_misalign, err_timeout        - single-cycle error pulses
//
// state    | meaning
// MemIdle  | waiting for a Cpu request; Cpu enabled
// MemBeat  | beat beat_idx_q outstanding on memory; Cpu stalled
module cpu_mem_ctrl
    import cpu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = mem_ctrl_timeout_cyc
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_rd,
    input  logic                  cpu_req_wr,
    input  logic [1:0]            cpu_req_size,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_MAX_W-1:0] cpu_wr_data,
    output logic                  cpu_enable,
    output logic [DATA_MAX_W-1:0] cpu_data_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [1:0]            mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [MEM_W-1:0]      mem_wr_data,
    input  logic [MEM_W-1:0]      mem_rd_data,
    input  logic                  mem_ack,
    output logic                  err_misalign,
    output logic                  err_timeout
);

    MemCtrlState           state_q;
    logic [ADDR_W-1:0]     addr_q;
    ReqDataSz              size_q;
    logic [DATA_MAX_W-1:0] wr_data_q;
    logic                  is_read_q;
    logic [1:0]            beat_idx_q;
    logic [1:0]            num_beats_q;
    logic [7:0]            tmo_cnt_q;
    logic [DATA_MAX_W-1:0] rd_asm_q;

    ReqDataSz              req_size;
    logic [1:0]            be_steer;
    logic [MEM_W-1:0]      wr_steer;
    logic [DATA_MAX_W-1:0] rd_merged;
    logic [DATA_MAX_W-1:0] rd_result;
    logic [ADDR_W-1:0]     beat_addr;
    logic                  last_beat;

    assign req_size  = ReqDataSz'(cpu_req_size);
    assign beat_addr = {addr_q[ADDR_W-1:1], 1'b0} + ADDR_W'({beat_idx_q, 1'b0});
    assign last_beat = (beat_idx_q == num_beats_q - 2'd1);

    cpu_mem_lane_steer u_steer (
        .size      (size_q),
        .addr_lsb  (addr_q[0]),
        .beat_idx  (beat_idx_q),
        .wr_data   (wr_data_q),
        .rd_data   (mem_rd_data),
        .rd_asm    (rd_asm_q),
        .be        (be_steer),
        .wr_beat   (wr_steer),
        .rd_merged (rd_merged),
        .rd_result (rd_result)
    );

    // Beat fields derive only from registers, so they hold steady until the ack edge;
    // gating with mem_req keeps them at zero while idle.
    assign mem_we      = mem_req & ~is_read_q;
    assign mem_be      = mem_req ? be_steer  : 2'b00;
    assign mem_addr    = mem_req ? beat_addr : '0;
    assign mem_wr_data = mem_req ? wr_steer  : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MemIdle;
            addr_q       <= '0;
            size_q       <= ReqDataSz8;
            wr_data_q    <= '0;
            is_read_q    <= 1'b0;
            beat_idx_q   <= '0;
            num_beats_q  <= '0;
            tmo_cnt_q    <= '0;
            rd_asm_q     <= '0;
            mem_req      <= 1'b0;
            cpu_enable   <= 1'b1;
            cpu_data_in  <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;

            case (state_q)
                MemIdle: begin
                    if (cpu_req_rd | cpu_req_wr) begin
                        if (req_size != ReqDataSz8 && cpu_addr[0]) begin
                            err_misalign <= 1'b1;
                            cpu_data_in  <= '0;
                        end else begin
                            addr_q      <= cpu_addr;
                            size_q      <= req_size;
                            wr_data_q   <= cpu_wr_data;
                            is_read_q   <= cpu_req_rd;   // read wins when both are set
                            num_beats_q <= mem_ctrl_num_beats(req_size);
                            beat_idx_q  <= '0;
                            tmo_cnt_q   <= '0;
                            rd_asm_q    <= '0;
                            mem_req     <= 1'b1;
                            cpu_enable  <= 1'b0;
                            state_q     <= MemBeat;
                        end
                    end
                end

                MemBeat: begin
                    if (mem_ack) begin
                        if (is_read_q)
                            rd_asm_q <= rd_merged;
                        if (last_beat) begin
                            if (is_read_q)
                                cpu_data_in <= rd_result;
                            mem_req    <= 1'b0;
                            cpu_enable <= 1'b1;
                            state_q    <= MemIdle;
                        end else begin
                            beat_idx_q <= beat_idx_q + 2'd1;
                            tmo_cnt_q  <= '0;
                        end
                    end else if (tmo_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                        // This edge ends the TIMEOUT_CYC-th unacked cycle of the beat.
                        mem_req     <= 1'b0;
                        err_timeout <= 1'b1;
                        cpu_data_in <= '1;
                        cpu_enable  <= 1'b1;
                        state_q     <= MemIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end

                default: state_q <= MemIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
module tb_cpu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_rd, cpu_req_wr;
    logic [1:0]  cpu_req_size;
    logic [31:0] cpu_addr;
    logic [47:0] cpu_wr_data;
    logic        cpu_enable;
    logic [47:0] cpu_data_in;
    logic        mem_req, mem_we;
    logic [1:0]  mem_be;
    logic [31:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_rd_data;
    logic        mem_ack;
    logic        err_misalign, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem_model [logic [31:0]];
    logic [47:0] exp_data;

    cpu_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_rd   (cpu_req_rd),
        .cpu_req_wr   (cpu_req_wr),
        .cpu_req_size (cpu_req_size),
        .cpu_addr     (cpu_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_enable   (cpu_enable),
        .cpu_data_in  (cpu_data_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .mem_ack      (mem_ack),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_model.exists(a))
            return mem_model[a];
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h3C;
    endfunction

    task automatic preload_hw(input logic [31:0] a, input logic [15:0] v);
        mem_model[a]      = v[7:0];
        mem_model[a + 1]  = v[15:8];
    endtask

    task automatic clear_req();
        cpu_req_rd   = 1'b0;
        cpu_req_wr   = 1'b0;
    endtask

    // One complete Cpu transfer with the bench acting as memory.
    // waits: idle cycles before the ack of beat 0/1/2. junk: drive stray requests while stalled.
    task automatic xfer(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [47:0] wd, input int w0, input int w1, input int w2, input bit junk);
        int          waits[3];
        int          nbytes, nbeats, stall, exp_stall;
        bit          is_rd;
        logic [47:0] exp_rd;
        logic [31:0] base, ba;
        logic [1:0]  ebe;
        logic [15:0] ewd;

        waits[0] = w0; waits[1] = w1; waits[2] = w2;
        is_rd  = rd;
        nbytes = (sz == 2'd3) ? 6 : (1 << sz);
        nbeats = (nbytes + 1) / 2;
        exp_rd = '0;
        if (sz == 2'd0)
            exp_rd[7:0] = rd_byte(a);
        else
            for (int i = 0; i < nbytes; i++) exp_rd[8*i +: 8] = rd_byte(a + 32'(i));

        // A stray ack while idle must have no effect.
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            check_val("idle_ack_req", mem_req, 1'b0);
            check_val("idle_ack_en", cpu_enable, 1'b1);
        end

        @(negedge clk);
        cpu_req_rd   = rd;
        cpu_req_wr   = wr;
        cpu_req_size = sz;
        cpu_addr     = a;
        cpu_wr_data  = wd;
        @(negedge clk);
        clear_req();

        if (sz != 2'd0 && a[0]) begin
            check_val("mis_pulse", err_misalign, 1'b1);
            check_val("mis_req", mem_req, 1'b0);
            check_val("mis_en", cpu_enable, 1'b1);
            check_val("mis_data", cpu_data_in, 48'h0);
            exp_data = '0;
            @(negedge clk);
            check_val("mis_pulse_end", err_misalign, 1'b0);
            check_val("mis_req2", mem_req, 1'b0);
            check_val("mis_en2", cpu_enable, 1'b1);
            return;
        end

        stall = 0;
        exp_stall = 0;
        base = {a[31:1], 1'b0};
        for (int k = 0; k < nbeats; k++) begin
            ba  = base + 32'(2 * k);
            ebe = (sz == 2'd0) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
            ewd = (sz == 2'd0) ? {wd[7:0], wd[7:0]} : wd[16*k +: 16];
            exp_stall += waits[k] + 1;
            for (int j = 0; j <= waits[k]; j++) begin
                clear_req();
                check_val("beat_req", mem_req, 1'b1);
                check_val("beat_addr", mem_addr, ba);
                check_val("beat_be", mem_be, ebe);
                check_val("beat_we", mem_we, !is_rd);
                if (!is_rd)
                    check_val("beat_wdata", mem_wr_data, ewd);
                if (cpu_enable == 1'b0)
                    stall++;
                if (j == waits[k]) begin
                    mem_ack     = 1'b1;
                    mem_rd_data = {rd_byte(ba + 1), rd_byte(ba)};
                    if (!is_rd) begin
                        if (ebe[0]) mem_model[ba]     = ewd[7:0];
                        if (ebe[1]) mem_model[ba + 1] = ewd[15:8];
                    end
                end else begin
                    mem_ack     = 1'b0;
                    mem_rd_data = 16'($urandom);
                    if (junk) begin
                        cpu_req_rd   = 1'($urandom);
                        cpu_req_wr   = 1'($urandom);
                        cpu_req_size = 2'($urandom);
                        cpu_addr     = $urandom;
                        cpu_wr_data  = {16'($urandom), 32'($urandom)};
                    end
                end
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        clear_req();
        check_val("done_req", mem_req, 1'b0);
        check_val("done_en", cpu_enable, 1'b1);
        check_val("stall_cycles", 64'(stall), 64'(exp_stall));
        if (is_rd)
            exp_data = exp_rd;
        check_val("cpu_data_in", cpu_data_in, exp_data);
    endtask

    task automatic timeout_xfer(input logic [31:0] a);
        int cnt;
        @(negedge clk);
        cpu_req_rd   = 1'b1;
        cpu_req_size = 2'd2;
        cpu_addr     = a;
        @(negedge clk);
        clear_req();
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 400) begin
            if (cpu_enable !== 1'b0) begin
                check_val("tmo_stall", cpu_enable, 1'b0);
            end
            cnt++;
            @(negedge clk);
        end
        check_val("tmo_cycles", 64'(cnt), 64'd255);
        check_val("tmo_pulse", err_timeout, 1'b1);
        check_val("tmo_data", cpu_data_in, 48'hFFFF_FFFF_FFFF);
        check_val("tmo_en", cpu_enable, 1'b1);
        exp_data = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        check_val("tmo_pulse_end", err_timeout, 1'b0);
        check_val("tmo_req_idle", mem_req, 1'b0);
    endtask

    task automatic reset_mid_write();
        @(negedge clk);
        cpu_req_wr   = 1'b1;
        cpu_req_size = 2'd2;
        cpu_addr     = 32'h500;
        cpu_wr_data  = 48'h0000_9ABC_DEF0;
        @(negedge clk);
        clear_req();
        check_val("rw_beat0_addr", mem_addr, 32'h500);
        mem_ack = 1'b1;
        preload_hw(32'h500, 16'hDEF0);
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("rw_beat1_addr", mem_addr, 32'h502);
        rst = 1'b1;
        @(negedge clk);
        check_val("rw_rst_req", mem_req, 1'b0);
        check_val("rw_rst_en", cpu_enable, 1'b1);
        check_val("rw_rst_addr", mem_addr, 32'h0);
        check_val("rw_rst_data", cpu_data_in, 48'h0);
        exp_data = '0;
        rst = 1'b0;
        @(negedge clk);
        xfer(1'b1, 1'b0, 2'd1, 32'h500, 48'h0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        clear_req();
        cpu_req_size = 2'd0;
        cpu_addr     = '0;
        cpu_wr_data  = '0;
        mem_rd_data  = '0;
        mem_ack      = 1'b0;
        exp_data     = '0;

        repeat (3) @(negedge clk);
        check_val("rst_en", cpu_enable, 1'b1);
        check_val("rst_req", mem_req, 1'b0);
        check_val("rst_we", mem_we, 1'b0);
        check_val("rst_be", mem_be, 2'b00);
        check_val("rst_addr", mem_addr, 32'h0);
        check_val("rst_wdata", mem_wr_data, 16'h0);
        check_val("rst_data", cpu_data_in, 48'h0);
        check_val("rst_mis", err_misalign, 1'b0);
        check_val("rst_tmo", err_timeout, 1'b0);
        rst = 1'b0;

        preload_hw(32'h100, 16'h5678);
        preload_hw(32'h102, 16'h1234);
        xfer(1'b1, 1'b0, 2'd2, 32'h100, 48'h0, 0, 0, 0, 1'b0);
        check_val("t1_data", cpu_data_in, 48'h0000_1234_5678);

        preload_hw(32'h200, 16'h1111);
        preload_hw(32'h202, 16'h2222);
        preload_hw(32'h204, 16'h3333);
        xfer(1'b1, 1'b0, 2'd3, 32'h200, 48'h0, 0, 3, 0, 1'b0);
        check_val("t2_data", cpu_data_in, 48'h3333_2222_1111);

        xfer(1'b0, 1'b1, 2'd0, 32'h301, 48'h0000_0000_00AB, 0, 0, 0, 1'b0);
        mem_model[32'h300] = 8'h00;
        mem_model[32'h301] = 8'hCD;
        xfer(1'b1, 1'b0, 2'd0, 32'h301, 48'h0, 0, 0, 0, 1'b0);
        check_val("t3_data", cpu_data_in, 48'hCD);

        xfer(1'b1, 1'b0, 2'd1, 32'h401, 48'h0, 0, 0, 0, 1'b0);
        timeout_xfer(32'h600);
        reset_mid_write();

        // Read-and-write together resolves to a read.
        xfer(1'b1, 1'b1, 2'd2, 32'h700, 48'h1234_5678_9ABC, 1, 2, 0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            int          sel;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [47:0] wd;
            sel = $urandom_range(0, 4);
            sz  = 2'($urandom);
            a   = 32'h1000 + 32'($urandom_range(0, 63));
            wd  = {16'($urandom), 32'($urandom)};
            xfer(sel != 1 && sel != 3, sel >= 1, sz, a, wd,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
